// File: rtl/fft_pkg.sv
// Shared widths, FSM state encoding and the power clip helper for the FFT power accumulator.
package fft_pkg;

  localparam int PWR_W = 35;
  localparam int BIN_W = 16;
  localparam int SQ_W  = 32;
  localparam int ACC_W = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DUMP = 2'd2
  } state_t;

  // Clip to 2^34-1; bit 34 of the result is always zero.
  function automatic logic [PWR_W-1:0] cap_pwr(input logic [ACC_W-1:0] a);
    if (|a[ACC_W-1:PWR_W-1]) return {1'b0, {(PWR_W-1){1'b1}}};
    else                     return {1'b0, a[PWR_W-2:0]};
  endfunction

endpackage

// File: rtl/fft_cplx_sq.sv
// Registered complex magnitude-squared: p = re^2 + im^2, one cycle, loads only when en is high.
module fft_cplx_sq
  import fft_pkg::*;
(
  input  logic                    clk,
  input  logic                    arstb,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [BIN_W-1:0] re,
  input  logic signed [BIN_W-1:0] im,
  output logic        [SQ_W-1:0]  p
);

  logic signed [SQ_W-1:0] re_x, im_x, re_sq, im_sq;
  logic        [SQ_W-1:0] p_nxt;

  // Each square is at most 2^30, so the unsigned sum (max 2^31) never overflows 32 bits.
  always_comb begin
    re_x  = SQ_W'(re);
    im_x  = SQ_W'(im);
    re_sq = re_x * re_x;
    im_sq = im_x * im_x;
    p_nxt = $unsigned(re_sq) + $unsigned(im_sq);
  end

  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb)   p <= '0;
    else if (clr) p <= '0;
    else if (en)  p <= p_nxt;
  end

endmodule

// File: rtl/fft_pwr_acc.sv
// Frame power accumulator: sums |X|^2 over FFT bins, clips to 34 bits; result 2 cycles after the final bin.
// No backpressure, freeze stalls everything; `define FFT_PWR_ACC_PEAK_EN adds the peak_idx output.
module fft_pwr_acc
  import fft_pkg::*;
#(
  parameter int FRAME_LOG2 = 6
) (
  input  logic                    clk,
  input  logic                    arstb,
  input  logic                    rstb,
  input  logic                    freeze,
  input  logic                    in_valid,
  input  logic signed [BIN_W-1:0] in_re,
  input  logic signed [BIN_W-1:0] in_im,
  input  logic                    in_last,
  output logic [PWR_W-1:0]        pwr,
  output logic                    pwr_valid,
  output logic                    sat,
  output logic [FRAME_LOG2-1:0]   bin_cnt
`ifdef FFT_PWR_ACC_PEAK_EN
  ,
  output logic [FRAME_LOG2-1:0]   peak_idx
`endif
);

  localparam logic [FRAME_LOG2-1:0] LAST_BIN = '1;

  logic             accept, frame_end;
  logic             s1_vld, s1_first, s1_end;
  logic [SQ_W-1:0]  s1_p;
  logic [ACC_W-1:0] acc;
  state_t           state, state_nxt;

  assign accept    = in_valid & ~freeze & rstb;
  assign frame_end = in_last | (bin_cnt == LAST_BIN);

  fft_cplx_sq u_sq (
    .clk   (clk),
    .arstb (arstb),
    .clr   (!rstb),
    .en    (accept),
    .re    (in_re),
    .im    (in_im),
    .p     (s1_p)
  );

  // Stage 1 sideband travels alongside the squarer output.
  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb) begin
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_end   <= 1'b0;
      bin_cnt  <= '0;
    end else if (!rstb) begin
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_end   <= 1'b0;
      bin_cnt  <= '0;
    end else if (!freeze) begin
      s1_vld <= accept;
      if (accept) begin
        s1_first <= (bin_cnt == '0);
        s1_end   <= frame_end;
        bin_cnt  <= frame_end ? '0 : bin_cnt + FRAME_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb)                  acc <= '0;
    else if (!rstb)              acc <= '0;
    else if (!freeze && s1_vld)  acc <= s1_first ? ACC_W'(s1_p) : acc + ACC_W'(s1_p);
  end

  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb)       state <= IDLE;
    else if (!rstb)   state <= IDLE;
    else if (!freeze) state <= state_nxt;
  end

  // Staying in DUMP covers a one-bin frame that closes right behind the previous one.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = ACC;
      ACC:  if (s1_vld && s1_end) state_nxt = DUMP;
      DUMP: begin
        if (s1_vld && s1_end)      state_nxt = DUMP;
        else if (s1_vld || accept) state_nxt = ACC;
        else                       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // pwr/sat hold through freeze; the strobe drops so a held DUMP emits exactly one pulse once freeze falls.
  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb) begin
      pwr       <= '0;
      pwr_valid <= 1'b0;
      sat       <= 1'b0;
    end else if (!rstb) begin
      pwr       <= '0;
      pwr_valid <= 1'b0;
      sat       <= 1'b0;
    end else if (freeze) begin
      pwr_valid <= 1'b0;
    end else begin
      pwr_valid <= (state == DUMP);
      if (state == DUMP) begin
        pwr <= cap_pwr(acc);
        sat <= |acc[ACC_W-1:PWR_W-1];
      end
    end
  end

`ifdef FFT_PWR_ACC_PEAK_EN
  logic [FRAME_LOG2-1:0] s1_idx, peak_bin;
  logic [SQ_W-1:0]       peak_p;

  // Strict compare keeps the lowest index on ties.
  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb) begin
      s1_idx   <= '0;
      peak_bin <= '0;
      peak_p   <= '0;
      peak_idx <= '0;
    end else if (!rstb) begin
      s1_idx   <= '0;
      peak_bin <= '0;
      peak_p   <= '0;
      peak_idx <= '0;
    end else if (!freeze) begin
      if (accept) s1_idx <= bin_cnt;
      if (s1_vld && (s1_first || s1_p > peak_p)) begin
        peak_p   <= s1_p;
        peak_bin <= s1_idx;
      end
      if (state == DUMP) peak_idx <= peak_bin;
    end
  end
`endif

endmodule

// File: tb/tb_fft_pwr_acc.sv
// Directed bench for fft_pwr_acc: stimulus pushes hand-computed frame results, a monitor pops and compares.
module tb_fft_pwr_acc;

  logic               clk = 1'b0;
  logic               arstb, rstb, freeze, last;
  logic               vld6, vld2;
  logic signed [15:0] re, im;

  logic [34:0] pwr6, pwr2;
  logic        pv6, pv2, sat6, sat2;
  logic [5:0]  bc6;
  logic [1:0]  bc2;
`ifdef FFT_PWR_ACC_PEAK_EN
  logic [5:0]  pk6;
  logic [1:0]  pk2;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fft_pwr_acc #(.FRAME_LOG2(6)) dut6 (
    .clk(clk), .arstb(arstb), .rstb(rstb), .freeze(freeze), .in_valid(vld6),
    .in_re(re), .in_im(im), .in_last(last),
    .pwr(pwr6), .pwr_valid(pv6), .sat(sat6), .bin_cnt(bc6)
`ifdef FFT_PWR_ACC_PEAK_EN
    , .peak_idx(pk6)
`endif
  );

  fft_pwr_acc #(.FRAME_LOG2(2)) dut2 (
    .clk(clk), .arstb(arstb), .rstb(rstb), .freeze(freeze), .in_valid(vld2),
    .in_re(re), .in_im(im), .in_last(last),
    .pwr(pwr2), .pwr_valid(pv2), .sat(sat2), .bin_cnt(bc2)
`ifdef FFT_PWR_ACC_PEAK_EN
    , .peak_idx(pk2)
`endif
  );

  typedef struct {
    logic [34:0] pwr;
    logic        sat;
    int          cyc;
    int          peak;
  } exp_t;

  exp_t q6[$];
  exp_t q2[$];
  exp_t e6, e2;
  int   checks = 0;
  int   passed = 0;
  int   k6 = 0;
  int   k2 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) $display("FAIL %s: got %0d, expected %0d", name, act, req);
    else passed++;
  endtask

  // Inputs change on the falling edge; the accepting rising edge is cyc+1.
  task automatic drive(input logic v6, input logic v2, input int r, input int i,
                       input logic l, input logic f);
    @(negedge clk);
    vld6 = v6; vld2 = v2; re = 16'(r); im = 16'(i); last = l; freeze = f;
    if (v6 && !f) k6 = cyc + 1;
    if (v2 && !f) k2 = cyc + 1;
  endtask

  task automatic s6(input int r, input int i, input logic l);
    drive(1'b1, 1'b0, r, i, l, 1'b0);
  endtask

  task automatic exp6(input logic [34:0] p, input logic s, input int pk);
    q6.push_back('{pwr: p, sat: s, cyc: k6 + 2, peak: pk});
  endtask

  task automatic exp2(input logic [34:0] p, input logic s, input int pk);
    q2.push_back('{pwr: p, sat: s, cyc: k2 + 2, peak: pk});
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    while ((q6.size() != 0 || q2.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk(name, 64'(q6.size() + q2.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (pv6) begin
      if (q6.size() == 0) begin
        chk("dut6 unexpected pwr_valid", 64'(pwr6), 64'd0);
      end else begin
        e6 = q6.pop_front();
        chk("dut6 pwr", 64'(pwr6), 64'(e6.pwr));
        chk("dut6 sat", 64'(sat6), 64'(e6.sat));
        chk("dut6 latency cycle", 64'(cyc), 64'(e6.cyc));
`ifdef FFT_PWR_ACC_PEAK_EN
        chk("dut6 peak_idx", 64'(pk6), 64'(e6.peak));
`endif
      end
    end
    if (pv2) begin
      if (q2.size() == 0) begin
        chk("dut2 unexpected pwr_valid", 64'(pwr2), 64'd0);
      end else begin
        e2 = q2.pop_front();
        chk("dut2 pwr", 64'(pwr2), 64'(e2.pwr));
        chk("dut2 sat", 64'(sat2), 64'(e2.sat));
        chk("dut2 latency cycle", 64'(cyc), 64'(e2.cyc));
`ifdef FFT_PWR_ACC_PEAK_EN
        chk("dut2 peak_idx", 64'(pk2), 64'(e2.peak));
`endif
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    arstb = 1'b0; rstb = 1'b1; freeze = 1'b0; last = 1'b0;
    vld6 = 1'b0; vld2 = 1'b0; re = '0; im = '0;
    repeat (3) @(negedge clk);
    chk("reset pwr", 64'(pwr6), 64'd0);
    chk("reset pwr_valid", 64'(pv6), 64'd0);
    chk("reset sat", 64'(sat6), 64'd0);
    chk("reset bin_cnt", 64'(bc6), 64'd0);
    chk("reset bin_cnt dut2", 64'(bc2), 64'd0);
    arstb = 1'b1;
    repeat (2) @(negedge clk);

    // 4 x (3,4) with last: 4 * 25
    for (int n = 0; n < 4; n++) s6(3, 4, n == 3);
    exp6(35'd100, 1'b0, 0);
    drain("drain in_last frame");
    chk("bin_cnt after frame", 64'(bc6), 64'd0);

    // synchronous reset mid-frame drops the partial frame
    s6(9, 9, 1'b0);
    s6(9, 9, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    rstb = 1'b0;
    @(negedge clk);
    chk("rstb pwr", 64'(pwr6), 64'd0);
    chk("rstb bin_cnt", 64'(bc6), 64'd0);
    rstb = 1'b1;
    drain("drain after rstb");

    // 64 bins of (-32768,-32768) end by count: 64 * 2^31 = 2^37 clips
    for (int n = 0; n < 64; n++) s6(-32768, -32768, 1'b0);
    exp6(35'h3_FFFF_FFFF, 1'b1, 0);
    drain("drain saturation frame");

    // freeze discards the (7,0) samples and holds bin_cnt
    s6(1, 0, 1'b0);
    s6(1, 0, 1'b0);
    for (int n = 0; n < 3; n++) drive(1'b1, 1'b0, 7, 0, 1'b0, 1'b1);
    chk("freeze bin_cnt hold", 64'(bc6), 64'd2);
    s6(1, 0, 1'b0);
    s6(1, 0, 1'b1);
    exp6(35'd4, 1'b0, 0);
    drain("drain freeze frame");

    // FRAME_LOG2=2, 8 x (1,1) without last: two frames of 4 * 2
    for (int n = 0; n < 8; n++) begin
      drive(1'b0, 1'b1, 1, 1, 1'b0, 1'b0);
      if (n == 3 || n == 7) exp2(35'd8, 1'b0, 0);
    end
    drain("drain wrap frames");
    chk("dut2 bin_cnt after wrap", 64'(bc2), 64'd0);

    // back-to-back: (1,0),(3,0) last then a one-bin frame (2,2) last
    s6(1, 0, 1'b0);
    s6(3, 0, 1'b1);
    exp6(35'd10, 1'b0, 1);
    s6(2, 2, 1'b1);
    exp6(35'd8, 1'b0, 0);
    drain("drain back-to-back");

    // async reset after 3 samples, then a (2,0) x 2 frame
    for (int n = 0; n < 3; n++) s6(5, 5, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    #2 arstb = 1'b0;
    @(negedge clk);
    chk("arstb pwr", 64'(pwr6), 64'd0);
    chk("arstb pwr_valid", 64'(pv6), 64'd0);
    chk("arstb sat", 64'(sat6), 64'd0);
    chk("arstb bin_cnt", 64'(bc6), 64'd0);
    @(negedge clk);
    arstb = 1'b1;
    s6(2, 0, 1'b0);
    s6(2, 0, 1'b1);
    exp6(35'd8, 1'b0, 0);
    drain("drain after arstb");

`ifdef FFT_PWR_ACC_PEAK_EN
    // p = 1,25,25,4: tie between bins 1 and 2 resolves to 1
    s6(1, 0, 1'b0);
    s6(0, 5, 1'b0);
    s6(3, 4, 1'b0);
    s6(2, 0, 1'b1);
    exp6(35'd55, 1'b0, 1);
    drain("drain peak frame");
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
